// File: rtl/rgb_sram_writer_if.sv
// rgb_sram_writer_if
//   Bundles the pixel stream handshake coming from the colour-space
//   conversion stage with the SRAM write port driven by the writer.
//
//   master : the environment side. It drives the pixel stream and
//            observes the SRAM write port.
//   slave  : the writer side. It sinks the pixel stream and drives
//            the SRAM write port.
//
//   Signals:
//     pixel_valid      upstream has a pixel on R_in/G_in/B_in
//     R_in/G_in/B_in   8-bit pixel components
//     pixel_ready      writer accepts a pixel this cycle
//     SRAM_address     18-bit write address
//     SRAM_write_data  16-bit write data
//     SRAM_we_n        active-low write enable
interface rgb_sram_writer_if;
  logic        pixel_valid;
  logic [7:0]  R_in;
  logic [7:0]  G_in;
  logic [7:0]  B_in;
  logic        pixel_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    output pixel_valid, R_in, G_in, B_in,
    input  pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    input  pixel_valid, R_in, G_in, B_in,
    output pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/rgb_sram_writer.sv
// rgb_sram_writer
//   Output stage of the decompressor datapath. Accepts 24-bit RGB
//   pixels over a valid/ready handshake, packs each pixel pair into
//   three 16-bit words ({R0,G0}, {B0,R1}, {G1,B1}) and writes them to
//   consecutive SRAM addresses starting at BASE_ADDR.
//
//   Parameters:
//     BASE_ADDR   first SRAM word address of the RGB region
//     NUM_PIXELS  pixels per frame, must be even
//
//   Ports:
//     Clock_50  system clock, rising edge
//     Reset     asynchronous, active-high
//     Start     one-cycle frame start pulse (accepted in S_IDLE/S_DONE)
//     Busy      high from accepted Start until the last write completes
//     Done      high once the frame is written, until the next Start
//     pix       pixel stream in, SRAM write port out (slave modport)
module rgb_sram_writer #(
  parameter logic [17:0] BASE_ADDR  = 18'd146944,
  parameter int          NUM_PIXELS = 76800
) (
  input  logic               Clock_50,
  input  logic               Reset,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  rgb_sram_writer_if.slave   pix
);

  localparam int          NUM_PAIRS = NUM_PIXELS / 2;
  localparam logic [16:0] LAST_PAIR = 17'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_WR0,
    S_WR1,
    S_WR2,
    S_DONE
  } state_t;

  state_t      state_q,  state_d;
  logic [16:0] pair_q,   pair_d;
  logic [17:0] addr_q,   addr_d;
  logic [15:0] data_q,   data_d;
  logic        we_n_q,   we_n_d;
  logic        ready_q,  ready_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic [7:0]  r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;
  logic [7:0]  r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;

  logic        handshake;

  // pixel_ready is registered and is high exactly in the accept states,
  // so the handshake is simply valid qualified by the registered ready.
  assign handshake = pix.pixel_valid & ready_q;

  // Next-state logic. Every registered output is computed for the state
  // being entered, so the SRAM port shows the word of the current write
  // state and address/data/we_n always change together.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_n_d  = we_n_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;
    r0_d    = r0_q;
    g0_d    = g0_q;
    b0_d    = b0_q;
    r1_d    = r1_q;
    g1_d    = g1_q;
    b1_d    = b1_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_ACC0;
          pair_d  = 17'd0;
          addr_d  = BASE_ADDR;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ready_d = 1'b1;
        end
      end

      S_ACC0: begin
        if (handshake) begin
          r0_d    = pix.R_in;
          g0_d    = pix.G_in;
          b0_d    = pix.B_in;
          state_d = S_ACC1;
        end
      end

      S_ACC1: begin
        if (handshake) begin
          r1_d    = pix.R_in;
          g1_d    = pix.G_in;
          b1_d    = pix.B_in;
          state_d = S_WR0;
          ready_d = 1'b0;
          we_n_d  = 1'b0;
          // Word 0 only needs the first pixel, which is already latched.
          data_d  = {r0_q, g0_q};
        end
      end

      S_WR0: begin
        state_d = S_WR1;
        addr_d  = addr_q + 18'd1;
        data_d  = {b0_q, r1_q};
      end

      S_WR1: begin
        state_d = S_WR2;
        addr_d  = addr_q + 18'd1;
        data_d  = {g1_q, b1_q};
      end

      S_WR2: begin
        we_n_d = 1'b1;
        if (pair_q == LAST_PAIR) begin
          // Address is left on the final word so it never steps past
          // the end of the RGB region.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ACC0;
          pair_d  = pair_q + 17'd1;
          addr_d  = addr_q + 18'd1;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        we_n_d  = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Reset clears everything, including latched pixels and write data,
  // so nothing from an interrupted pair can reach the SRAM afterwards.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pair_q  <= 17'd0;
      addr_q  <= BASE_ADDR;
      data_q  <= 16'd0;
      we_n_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r0_q    <= 8'd0;
      g0_q    <= 8'd0;
      b0_q    <= 8'd0;
      r1_q    <= 8'd0;
      g1_q    <= 8'd0;
      b1_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r0_q    <= r0_d;
      g0_q    <= g0_d;
      b0_q    <= b0_d;
      r1_q    <= r1_d;
      g1_q    <= g1_d;
      b1_q    <= b1_d;
    end
  end

  assign pix.pixel_ready     = ready_q;
  assign pix.SRAM_address    = addr_q;
  assign pix.SRAM_write_data = data_q;
  assign pix.SRAM_we_n       = we_n_q;
  assign Busy                = busy_q;
  assign Done                = done_q;

endmodule

// File: tb/tb_rgb_sram_writer.sv
// tb_rgb_sram_writer
//   Bench for rgb_sram_writer. u_dut runs short frames (NUM_PIXELS=8)
//   with random pixels and random gaps; u_pair runs a single directed
//   pixel pair (NUM_PIXELS=2). Expected SRAM contents are derived from
//   the pixel byte stream: word i of a frame is bytes 2i and 2i+1 of
//   the R,G,B,R,G,B,... sequence, at address BASE+i.
module tb_rgb_sram_writer;
  localparam logic [17:0] BASE   = 18'd146944;
  localparam int          NPIX   = 8;
  localparam int          NWORDS = NPIX * 3 / 2;

  logic clk = 1'b0;
  logic rst;
  logic start8, start2;
  logic busy8, done8, busy2, done2;

  rgb_sram_writer_if pif ();
  rgb_sram_writer_if sif ();

  rgb_sram_writer #(.BASE_ADDR(BASE), .NUM_PIXELS(NPIX)) u_dut (
    .Clock_50 (clk),
    .Reset    (rst),
    .Start    (start8),
    .Busy     (busy8),
    .Done     (done8),
    .pix      (pif.slave)
  );

  rgb_sram_writer #(.BASE_ADDR(BASE), .NUM_PIXELS(2)) u_pair (
    .Clock_50 (clk),
    .Reset    (rst),
    .Start    (start2),
    .Busy     (busy2),
    .Done     (done2),
    .pix      (sif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t        wq[$];
  wr_t        sq[$];
  logic [7:0] px_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every cycle with we_n low is one SRAM write.
  always @(negedge clk) begin
    if (pif.SRAM_we_n === 1'b0) begin
      wq.push_back({pif.SRAM_address, pif.SRAM_write_data});
      checks++;
      assert (pif.pixel_ready === 1'b0) else begin
        errors++;
        $error("FAIL ready_in_write: observed %0b expected 0", pif.pixel_ready);
      end
    end
    if (sif.SRAM_we_n === 1'b0) sq.push_back({sif.SRAM_address, sif.SRAM_write_data});
  end

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int gap, input bit pulse);
    bit ok;
    int g_n;
    g_n = (pulse && gap < 1) ? 1 : gap;
    if (g_n > 0) pif.pixel_valid = 1'b0;
    for (int i = 0; i < g_n; i++) begin
      if (pulse && i == 0) start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
    end
    pif.pixel_valid = 1'b1;
    pif.R_in = r;
    pif.G_in = g;
    pif.B_in = b;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (pif.pixel_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("handshake_timeout", {31'd0, ok}, 32'd1);
    px_bytes.push_back(r);
    px_bytes.push_back(g);
    px_bytes.push_back(b);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400 && done8 !== 1'b1; t++) @(negedge clk);
    chk("done_timeout", {31'd0, done8}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_write_count"}, wq.size(), NWORDS);
    n = (wq.size() < NWORDS) ? wq.size() : NWORDS;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, wq[i].a, BASE + 18'(i));
      chk({tag, "_data"}, wq[i].d, {px_bytes[2*i], px_bytes[2*i+1]});
    end
    chk({tag, "_busy_end"}, {31'd0, busy8}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int pulse_idx);
    wq.delete();
    px_bytes.delete();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_start_to_ready"}, {31'd0, pif.pixel_ready}, 32'd1);
    chk({tag, "_busy_start"}, {31'd0, busy8}, 32'd1);
    chk({tag, "_done_cleared"}, {31'd0, done8}, 32'd0);
    for (int i = 0; i < NPIX; i++)
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), int'($urandom_range(0, max_gap)), i == pulse_idx);
    pif.pixel_valid = 1'b0;
    wait_done();
    check_frame(tag);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, {31'd0, done8}, 32'd1);
    chk({tag, "_no_extra_writes"}, wq.size(), NWORDS);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    pif.pixel_valid = 1'b0;
    pif.R_in = 8'd0; pif.G_in = 8'd0; pif.B_in = 8'd0;
    sif.pixel_valid = 1'b0;
    sif.R_in = 8'd0; sif.G_in = 8'd0; sif.B_in = 8'd0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_we_n", {31'd0, pif.SRAM_we_n}, 32'd1);
    chk("rst_addr", pif.SRAM_address, BASE);
    chk("rst_data", pif.SRAM_write_data, 32'd0);
    chk("rst_ready", {31'd0, pif.pixel_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_pair_addr", sif.SRAM_address, BASE);
    rst = 1'b0;
    @(negedge clk);

    // Reset and Start together: Reset wins, block stays idle
    rst = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy8}, 32'd0);
    chk("rst_start_ready", {31'd0, pif.pixel_ready}, 32'd0);
    rst = 1'b0;
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_idle_busy", {31'd0, busy8}, 32'd0);
    chk("rst_start_idle_ready", {31'd0, pif.pixel_ready}, 32'd0);
    chk("rst_start_idle_done", {31'd0, done8}, 32'd0);

    // Single directed pair on the NUM_PIXELS=2 instance
    sq.delete();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("pair_start_to_ready", {31'd0, sif.pixel_ready}, 32'd1);
    chk("pair_busy", {31'd0, busy2}, 32'd1);
    sif.pixel_valid = 1'b1;
    sif.R_in = 8'h12; sif.G_in = 8'h34; sif.B_in = 8'h56;
    @(negedge clk);
    chk("pair_ready_acc1", {31'd0, sif.pixel_ready}, 32'd1);
    sif.R_in = 8'h78; sif.G_in = 8'h9A; sif.B_in = 8'hBC;
    @(negedge clk);
    sif.pixel_valid = 1'b0;
    chk("pair_w0_we", {31'd0, sif.SRAM_we_n}, 32'd0);
    chk("pair_w0_addr", sif.SRAM_address, 32'd146944);
    chk("pair_w0_data", sif.SRAM_write_data, 32'h1234);
    chk("pair_w0_ready", {31'd0, sif.pixel_ready}, 32'd0);
    @(negedge clk);
    chk("pair_w1_addr", sif.SRAM_address, 32'd146945);
    chk("pair_w1_data", sif.SRAM_write_data, 32'h5678);
    @(negedge clk);
    chk("pair_w2_addr", sif.SRAM_address, 32'd146946);
    chk("pair_w2_data", sif.SRAM_write_data, 32'h9ABC);
    @(negedge clk);
    chk("pair_end_we", {31'd0, sif.SRAM_we_n}, 32'd1);
    chk("pair_done", {31'd0, done2}, 32'd1);
    chk("pair_busy_end", {31'd0, busy2}, 32'd0);
    repeat (3) @(negedge clk);
    chk("pair_write_count", sq.size(), 32'd3);
    chk("pair_done_held", {31'd0, done2}, 32'd1);

    // Back-pressure frame, gaps of 0..7 cycles
    run_frame("bp", 7, -1);

    // Frame restarted from S_DONE with a stray Start mid-frame
    run_frame("midstart", 3, 3);

    // Reset while word 1 is on the bus
    wq.delete();
    px_bytes.delete();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    send_pixel(8'hA1, 8'hB2, 8'hC3, 0, 1'b0);
    send_pixel(8'hD4, 8'hE5, 8'hF6, 0, 1'b0);
    chk("wr0_we", {31'd0, pif.SRAM_we_n}, 32'd0);
    chk("wr0_data", pif.SRAM_write_data, 32'hA1B2);
    @(posedge clk);
    #2;
    chk("wr1_data_before_rst", pif.SRAM_write_data, 32'hC3D4);
    rst = 1'b1;
    #1;
    chk("wr1_rst_we_n", {31'd0, pif.SRAM_we_n}, 32'd1);
    chk("wr1_rst_addr", pif.SRAM_address, BASE);
    chk("wr1_rst_data", pif.SRAM_write_data, 32'd0);
    chk("wr1_rst_busy", {31'd0, busy8}, 32'd0);
    pif.pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("wr1_rst_writes", wq.size(), 32'd1);
    chk("wr1_rst_idle_ready", {31'd0, pif.pixel_ready}, 32'd0);
    chk("wr1_rst_idle_done", {31'd0, done8}, 32'd0);

    // Fresh frame after the interrupted one rewrites from BASE
    run_frame("after_rst", 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
